// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-level helpers.
// The S-box is held as one packed table, byte 0x00 in the top eight bits.
package aes_pkg;

  localparam int KW = 128;
  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load, status and round-key read signals between the controller and the cipher core.
// The core drives requests (master); the key-schedule controller answers (slave).
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic [KW-1:0] key_in;
  logic          key_valid;
  logic          key_ready;
  logic          key_clear;
  logic          busy;
  logic          keys_ready;
  logic          rk_rd_en;
  logic [3:0]    rk_rd_idx;
  logic [KW-1:0] rk_rd_data;
  logic          rk_rd_valid;
  logic          rk_rd_err;

  modport master (
    output key_in, key_valid, key_clear, rk_rd_en, rk_rd_idx,
    input  key_ready, busy, keys_ready, rk_rd_data, rk_rd_valid, rk_rd_err
  );

  modport slave (
    input  key_in, key_valid, key_clear, rk_rd_en, rk_rd_idx,
    output key_ready, busy, keys_ready, rk_rd_data, rk_rd_valid, rk_rd_err
  );

endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round, purely combinational.
// Words are taken MSB first; only the last word goes through RotWord/SubWord.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KW-1:0] prev_key,
  input  logic [7:0]    rcon,
  output logic [KW-1:0] next_key
);

  logic [31:0] w0, w1, w2, w3, rot, t, w4, w5, w6, w7;

  always_comb begin
    {w0, w1, w2, w3} = prev_key;
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon, 24'h0};
    w4  = w0 ^ t;
    w5  = w1 ^ w4;
    w6  = w2 ^ w5;
    w7  = w3 ^ w6;
    next_key = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one shared step over 10 cycles into an 11-entry key file.
// Load-to-ready 11 cycles; keys offered only in IDLE/READY; reads are registered, 1-cycle latency.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes_key_sched_ctrl_if.slave   bus
);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [3:0]    written_cnt_q, written_cnt_d;
  logic [KW-1:0] rk_q [0:NR];
  logic [KW-1:0] rk_d [0:NR];
  logic [KW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;

  logic [3:0]    prev_idx;
  logic [KW-1:0] step_prev, step_next;
  logic          rd_ok;

  assign prev_idx  = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign step_prev = rk_q[prev_idx];

  aes_key_step u_step (
    .prev_key (step_prev),
    .rcon     (rcon_q),
    .next_key (step_next)
  );

  // written_cnt never exceeds 11, so this also rejects indices above 10
  assign rd_ok = bus.rk_rd_en && (bus.rk_rd_idx < written_cnt_q);

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    rcon_d        = rcon_q;
    written_cnt_d = written_cnt_q;
    rk_d          = rk_q;
    rd_valid_d    = rd_ok;
    rd_err_d      = bus.rk_rd_en && !rd_ok;
    rd_data_d     = rd_ok ? rk_q[bus.rk_rd_idx] : rd_data_q;

    case (state_q)
      IDLE, READY: begin
        if (bus.key_valid) begin
          rk_d[0]       = bus.key_in;
          round_d       = 4'd1;
          rcon_d        = RCON_INIT;
          written_cnt_d = 4'd1;
          state_d       = EXPAND;
        end
      end
      EXPAND: begin
        rk_d[round_q] = step_next;
        written_cnt_d = written_cnt_q + 4'd1;
        round_d       = round_q + 4'd1;
        rcon_d        = xtime(rcon_q);
        if (round_q == 4'(NR)) begin
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.key_clear) begin
      state_d       = IDLE;
      round_d       = 4'd0;
      rcon_d        = RCON_INIT;
      written_cnt_d = 4'd0;
      rd_data_d     = '0;
      rd_valid_d    = 1'b0;
      rd_err_d      = 1'b0;
      for (int i = 0; i <= NR; i++) begin
        rk_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      round_q       <= 4'd0;
      rcon_q        <= RCON_INIT;
      written_cnt_q <= 4'd0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      rd_err_q      <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      rcon_q        <= rcon_d;
      written_cnt_q <= written_cnt_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_err_q      <= rd_err_d;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

  assign bus.key_ready   = (state_q == IDLE) || (state_q == READY);
  assign bus.busy        = (state_q == EXPAND);
  assign bus.keys_ready  = (state_q == READY);
  assign bus.rk_rd_data  = rd_data_q;
  assign bus.rk_rd_valid = rd_valid_q;
  assign bus.rk_rd_err   = rd_err_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Iterative AES-128 key-schedule controller. Replaces ten unrolled expansion stages with one shared round-key step sequenced over 10 cycles. Stores all 11 round keys (0 = cipher key, 1..10 = expanded) in an internal register file. Serves indexed, registered reads to the round datapath of the cipher/decipher core.

Parameters:
NR, 10, number of expanded round keys (AES-128 only; other values unsupported)
KW, 128, key and round-key width in bits

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
key_in  in  128  cipher key, sampled on the load handshake
key_valid  in  1  key load request
key_ready  out  1  controller can accept a key (IDLE or READY state)
key_clear  in  1  wipe all stored keys, return to IDLE
busy  out  1  expansion in progress
keys_ready  out  1  all 11 round keys valid
rk_rd_en  in  1  round-key read request
rk_rd_idx  in  4  round-key index 0..10
rk_rd_data  out  128  read data, registered
rk_rd_valid  out  1  rk_rd_data valid this cycle
rk_rd_err  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (rst=1 at an edge): state IDLE. All 11 storage entries = 0. Round counter = 0. rcon = 8'h01. written_cnt = 0.
- Output reset values: key_ready=1, busy=0, keys_ready=0, rk_rd_data=0, rk_rd_valid=0, rk_rd_err=0.
- rst has priority over every other input.
- States:
  - IDLE: key_ready=1. On key_valid: rk[0]<=key_in, round<=1, rcon<=01, written_cnt<=1, go to EXPAND.
  - EXPAND: busy=1, key_ready=0, key_valid ignored (no queuing).
    - Each cycle: rk[round] <= step(rk[round-1], rcon); written_cnt++; round++; rcon <= xtime(rcon).
    - xtime = shift left 1; XOR 8'h1b if bit 7 was set.
    - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
    - After the round-10 write: go to READY.
  - READY: keys_ready=1, key_ready=1. key_valid restarts exactly as from IDLE; keys_ready drops the next cycle.
- Latency: load handshake at edge T. rk[k] is written at edge T+k. keys_ready=1 after edge T+10. Load-to-ready = 11 cycles.
- key_clear (any state, lower priority than rst only): same effect as reset except rst itself is not required. It overrides a simultaneous key_valid.
- Reads (legal in any state):
  - On rk_rd_en at edge T, rk_rd_data/rk_rd_valid update after edge T (1-cycle latency).
  - Valid iff rk_rd_idx < written_cnt, evaluated before this edge's write. A same-cycle write to that index is not visible to the read.
  - rk_rd_idx > 10, or not yet written: rk_rd_valid=0, rk_rd_err=1 for one cycle, rk_rd_data holds its previous value.
  - rk_rd_en=0: rk_rd_valid=0, rk_rd_err=0.
- Key reload while reads are in flight: a read at the load edge returns old contents, since it is evaluated pre-write. From the next cycle only index 0 is valid.
- Round step (combinational):
  - w0..w3 = words of the previous key, MSB word first.
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}.
  - w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6.

Decomposition:
- Shared package aes_pkg: state enum {IDLE, EXPAND, READY}, KW, NR, RCON_INIT=8'h01, the S-box function/table, and the xtime function.
- One sub-module aes_key_step: purely combinational, inputs prev_key[127:0] and rcon[7:0], output next_key[127:0]. This is the single shared datapath instance.
- The controller owns the FSM, counters, rcon register, 11x128 register file and read port.

Test Plan:
- FIPS-197 vector: load key 2b7e151628aed2a6abf7158809cf4f3c. Expect keys_ready exactly 11 cycles after the handshake. rk[1]=a0fafe1788542cb123a339392a6c7605. rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Early read: during EXPAND, read idx 3 on the cycle rk[3] is written. Expect rk_rd_err=1, valid=0. The same read one cycle later returns the correct rk[3] with valid=1.
- Out-of-range read: idx 11 and idx 15 in READY. Expect rk_rd_err pulse, valid=0, data unchanged.
- Key during EXPAND: assert key_valid with key 000102...0f mid-expansion. Expect key_ready=0 and the key ignored. rk[10] still equals the FIPS value.
- Reload in READY: load 000102030405060708090a0b0c0d0e0f. Expect keys_ready=0 the next cycle. After 11 cycles rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- key_clear and rst mid-EXPAND (round 5): expect IDLE next cycle, keys_ready=0, and all reads return err. A fresh load then completes with correct keys.
